// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-bus controller: RV32I load/store
// funct3 values and the controller state encoding.
package mem_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: legality/alignment check for the incoming
// access, byte enables and lane replication for stores, and extraction plus
// sign/zero extension of the returned load word.
module mem_lane_align (
  input  logic        is_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic        access_ok,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_fmt
);
  import mem_ctrl_pkg::*;

  logic        legal;
  logic        aligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Legal funct3 depends on direction; alignment depends only on access size.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    if (is_write) begin
      legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end
    case (funct3[1:0])
      2'b01:   aligned = ~addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign access_ok = legal & aligned;

  // Stores replicate the datum across all lanes so the enables pick the target.
  always_comb begin
    be    = 4'b1111;
    wdata = '0;
    if (is_write) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  // Load lane select uses the offset captured at issue, not the live address.
  always_comb begin
    load_fmt = rdata;
    case (ld_addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_LB:   load_fmt = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   load_fmt = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  load_fmt = {24'b0, ld_byte};
      F3_LHU:  load_fmt = {16'b0, ld_half};
      default: load_fmt = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus sequencer. Issues one req/gnt/rvalid transaction per
// load or store, stalls the pipeline until it completes, and reports
// misaligned/illegal accesses and bus timeouts as single-cycle pulses.
//
// state | meaning
// IDLE  | no access in flight; a legal access is issued from here
// REQ   | bus_req held, waiting for bus_gnt
// WAIT  | load granted, waiting for bus_rvalid
// DONE  | one unstalled cycle so the pipeline moves past the access
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  import mem_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;
  logic             access;
  logic             access_ok;
  logic             cnt_last;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;
  logic [31:0]      load_fmt;

  assign access   = mem_MemRead | mem_MemWrite;
  assign cnt_last = (cnt == CNT_LAST);

  mem_lane_align u_lane (
    .is_write   (mem_MemWrite),
    .funct3     (mem_funct3),
    .addr_lo    (mem_alu_result[1:0]),
    .store_data (mem_write_data),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .rdata      (bus_rdata),
    .access_ok  (access_ok),
    .be         (be_next),
    .wdata      (wdata_next),
    .load_fmt   (load_fmt)
  );

  // Stall is combinational so the issuing cycle already holds the pipeline.
  assign stall = ((state == IDLE) && access && access_ok) ||
                 (state == REQ) || (state == WAIT);

  // Transaction sequencer with registered bus outputs and result pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      access_err  <= 1'b0;
      timeout_err <= 1'b0;
      ld_funct3   <= '0;
      ld_addr_lo  <= '0;
    end else begin
      load_valid  <= 1'b0;
      access_err  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (access_ok) begin
              bus_req    <= 1'b1;
              bus_we     <= mem_MemWrite;
              bus_addr   <= {mem_alu_result[31:2], 2'b00};
              bus_be     <= be_next;
              bus_wdata  <= wdata_next;
              ld_funct3  <= mem_funct3;
              ld_addr_lo <= mem_alu_result[1:0];
              cnt        <= '0;
              state      <= REQ;
            end else begin
              access_err <= 1'b1;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // A read granted in the last budgeted cycle cannot still receive
          // data in time, so it is treated as a timeout.
          if (bus_gnt && (bus_we || !cnt_last)) begin
            bus_req <= 1'b0;
            state   <= bus_we ? DONE : WAIT;
          end else if (cnt_last) begin
            bus_req     <= 1'b0;
            timeout_err <= 1'b1;
            load_data   <= '0;
            state       <= DONE;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid) begin
            load_data  <= load_fmt;
            load_valid <= 1'b1;
            state      <= DONE;
          end else if (cnt_last) begin
            timeout_err <= 1'b1;
            load_data   <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues directed and random
// accesses with chosen grant/rvalid delays and queues the expected bus
// request, stall length and result pulse; a negedge monitor checks them.
module tb_mem_access_ctrl;

  localparam int T = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_MemRead = 1'b0;
  logic        mem_MemWrite = 1'b0;
  logic [2:0]  mem_funct3 = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_write_data = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;
  logic        timeout_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_write_data (mem_write_data),
    .stall          (stall),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .access_err     (access_err),
    .timeout_err    (timeout_err),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_be         (bus_be),
    .bus_gnt        (bus_gnt),
    .bus_rvalid     (bus_rvalid),
    .bus_rdata      (bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          len;
  } bus_exp_t;

  // kind = {load_valid, access_err, timeout_err}
  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
  } resp_t;

  bus_exp_t bus_q[$];
  resp_t    resp_q[$];
  int       stall_q[$];
  int       checks = 0;
  int       failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=present required=none", name);
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_legal(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    int s = 1 << f3[1:0];
    if (s == 8) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    if (!wr && f3[2] && s == 4) return 1'b0;
    return (int'(addr[1:0]) % s) == 0;
  endfunction

  function automatic logic [3:0] model_be(input int s, input int off);
    int m = ((1 << s) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int s, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    logic [31:0] v = rd >> (8 * off);
    int s = 1 << f3[1:0];
    if (s == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (s == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    mem_funct3     = 3'($urandom_range(0, 7));
    mem_alu_result = $urandom();
    mem_write_data = $urandom();
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rword, input int g, input int r,
                         input bit rv_at_gnt);
    int s = 1 << f3[1:0];
    int off = int'(addr[1:0]);
    int need;
    int fin;
    int last;
    bit timed;
    bus_exp_t e;
    resp_t rs;
    if (!model_legal(wr, f3, addr)) begin
      rs.kind = 3'b010;
      rs.data = '0;
      resp_q.push_back(rs);
      for (int c = 0; c < 3; c++) begin
        if (c == 0) begin
          mem_MemRead = rd; mem_MemWrite = wr; mem_funct3 = f3;
          mem_alu_result = addr; mem_write_data = data;
        end else begin
          drive_idle();
        end
        bus_gnt    = 1'($urandom_range(0, 1));
        bus_rvalid = 1'($urandom_range(0, 1));
        bus_rdata  = $urandom();
        tick();
      end
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      return;
    end
    need  = wr ? g + 1 : g + 1 + r;
    timed = need > T;
    fin   = timed ? T : need;
    e.addr  = {addr[31:2], 2'b00};
    e.we    = wr;
    e.be    = wr ? model_be(s, off) : 4'hF;
    e.wdata = wr ? model_wdata(s, data) : 32'h0;
    e.len   = (g + 1 < T) ? g + 1 : T;
    bus_q.push_back(e);
    stall_q.push_back(fin + 1);
    if (timed) begin
      rs.kind = 3'b001; rs.data = '0; resp_q.push_back(rs);
    end else if (!wr) begin
      rs.kind = 3'b100; rs.data = model_load(f3, off, rword); resp_q.push_back(rs);
    end
    last = need;
    if (last < fin + 1) last = fin + 1;
    last += 2;
    for (int c = 0; c <= last; c++) begin
      if (c <= fin + 1) begin
        mem_MemRead = rd; mem_MemWrite = wr; mem_funct3 = f3;
        mem_alu_result = addr; mem_write_data = data;
      end else begin
        drive_idle();
      end
      bus_gnt    = (c == g + 1);
      bus_rvalid = (!wr && c == g + 1 + r) || (rv_at_gnt && c == g + 1);
      bus_rdata  = (!wr && c == g + 1 + r) ? rword : $urandom();
      tick();
    end
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_stall"}, 32'(stall), 32'h0);
    check({p, "_bus_req"}, 32'(bus_req), 32'h0);
    check({p, "_bus_we"}, 32'(bus_we), 32'h0);
    check({p, "_bus_addr"}, bus_addr, 32'h0);
    check({p, "_bus_wdata"}, bus_wdata, 32'h0);
    check({p, "_bus_be"}, 32'(bus_be), 32'h0);
    check({p, "_load_data"}, load_data, 32'h0);
    check({p, "_load_valid"}, 32'(load_valid), 32'h0);
    check({p, "_access_err"}, 32'(access_err), 32'h0);
    check({p, "_timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  // Reset while a load sits in WAIT, then a late rvalid that must be ignored.
  task automatic reset_in_wait();
    bus_exp_t e;
    e.addr = 32'h0000_0500; e.we = 1'b0; e.be = 4'hF; e.wdata = 32'h0; e.len = 1;
    bus_q.push_back(e);
    stall_q.push_back(4);
    for (int c = 0; c < 10; c++) begin
      if (c <= 2) begin
        mem_MemRead = 1'b1; mem_MemWrite = 1'b0; mem_funct3 = 3'b010;
        mem_alu_result = 32'h0000_0500; mem_write_data = $urandom();
      end else begin
        drive_idle();
      end
      reset_n    = (c != 3);
      bus_gnt    = (c == 1);
      bus_rvalid = (c == 6);
      bus_rdata  = 32'h1234_5678;
      tick();
      if (c == 3) check_all_zero("rst_wait");
    end
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  bit       p_req = 1'b0;
  bit       p_stall = 1'b0;
  int       req_run = 0;
  int       stall_run = 0;
  bus_exp_t cur;
  resp_t    mr;
  int       exp_stall;

  always @(negedge clk) begin
    if (bus_req && !p_req) begin
      if (bus_q.size() == 0) begin
        unexpected("bus_req_start");
      end else begin
        cur = bus_q.pop_front();
        check("bus_addr", bus_addr, cur.addr);
        check("bus_we", 32'(bus_we), 32'(cur.we));
        check("bus_be", 32'(bus_be), 32'(cur.be));
        check("bus_wdata", bus_wdata, cur.wdata);
      end
    end
    if (bus_req) begin
      req_run++;
    end else if (p_req) begin
      check("bus_req_len", 32'(req_run), 32'(cur.len));
      req_run = 0;
    end
    if (stall) begin
      stall_run++;
    end else if (p_stall) begin
      if (stall_q.size() == 0) begin
        unexpected("stall_episode");
      end else begin
        exp_stall = stall_q.pop_front();
        check("stall_len", 32'(stall_run), 32'(exp_stall));
      end
      stall_run = 0;
    end
    if (load_valid || access_err || timeout_err) begin
      if (resp_q.size() == 0) begin
        unexpected("result_pulse");
      end else begin
        mr = resp_q.pop_front();
        check("pulse_kind", {29'b0, load_valid, access_err, timeout_err}, {29'b0, mr.kind});
        if (mr.kind == 3'b010) begin
          check("err_prev_stall", 32'(p_stall), 32'h0);
          check("err_bus_req", 32'(bus_req), 32'h0);
        end else begin
          check("load_data", load_data, mr.data);
        end
      end
    end
    p_req   = bus_req;
    p_stall = stall;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    int          op;
    int          g;
    int          r;
    reset_n = 1'b0;
    drive_idle();
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1, 1'b0);
    run_txn(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_FF7F, 0, 1, 1'b0);
    run_txn(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_FF7F, 0, 1, 1'b0);
    run_txn(1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 32'h0, 0, 1, 1'b0);
    run_txn(1'b1, 1'b0, 3'b001, 32'h0000_0301, 32'h0, 32'h0, 0, 1, 1'b0);
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 3, 2, 1'b0);
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 32'h5555_AAAA, 20, 1, 1'b0);
    run_txn(1'b1, 1'b1, 3'b000, 32'h0000_0601, 32'h0000_00A5, 32'h0, 5, 1, 1'b1);
    run_txn(1'b1, 1'b0, 3'b101, 32'h0000_0702, 32'h0, 32'h9ABC_1234, 1, 1, 1'b1);
    reset_in_wait();
    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_0800, 32'h0BAD_F00D, 32'h0, 0, 1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      if ($urandom_range(0, 3) != 0) begin
        f3 = 3'($urandom_range(0, 2));
        if (!wr && $urandom_range(0, 1) == 1 && f3 != 3'd2) f3[2] = 1'b1;
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        case (f3[1:0])
          2'b01:   addr[0] = 1'b0;
          2'b10:   addr[1:0] = 2'b00;
          default: ;
        endcase
      end
      g = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 8) : $urandom_range(0, 3);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 6) : $urandom_range(1, 2);
      run_txn(rd, wr, f3, addr, $urandom(), $urandom(), g, r, 1'($urandom_range(0, 1)));
    end

    repeat (4) tick();
    check("bus_q_drained", 32'(bus_q.size()), 32'h0);
    check("stall_q_drained", 32'(stall_q.size()), 32'h0);
    check("resp_q_drained", 32'(resp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences every data-memory access held in the EX/MEM pipeline register onto a single-port data bus with a req/gnt/rvalid handshake.
- Asserts a pipeline stall, holding the EX/MEM register and all earlier stages, until each load or store completes.
- Generates byte enables and write-lane replication, formats load data (sign or zero extension), and flags misaligned/illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT before abort; must be >= 1.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- mem_MemRead  in  1  MEM-stage load.
- mem_MemWrite  in  1  MEM-stage store.
- mem_funct3  in  3  access size/sign (RV32I encoding).
- mem_alu_result  in  32  byte address.
- mem_write_data  in  32  store data, right-aligned.
- stall  out  1  freeze EX/MEM and earlier stages.
- load_data  out  32  formatted load result.
- load_valid  out  1  1-cycle pulse; load_data valid.
- access_err  out  1  1-cycle pulse: misaligned or illegal funct3.
- timeout_err  out  1  1-cycle pulse: bus did not respond in time.
- bus_req  out  1  request, held until granted.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data word.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low (reset_n). Reset forces state IDLE and drives all registered outputs to 0: bus_req, bus_we, bus_addr, bus_wdata, bus_be, load_data, load_valid, access_err, timeout_err, and the counter. A reset asserted mid-transaction drops bus_req at that edge. Any later bus_gnt/bus_rvalid is ignored while in IDLE.
- Access = MemRead | MemWrite. If both are asserted, treat as a write.
- Legal funct3 values: load 0/1/2/4/5 (LB/LH/LW/LBU/LHU); store 0/1/2. Any other value is illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
- State IDLE:
  - Legal aligned access: register bus_addr/we/be/wdata, set bus_req=1, go to REQ. stall=1 combinationally in this cycle.
  - Illegal or misaligned access: pulse access_err next cycle; no bus activity, no stall, stay IDLE.
- State REQ: stall=1; counter increments.
  - bus_gnt=1: drop bus_req. Write goes to DONE; read goes to WAIT.
- State WAIT: stall=1; counter continues.
  - bus_rvalid=1: latch formatted load_data, pulse load_valid, go to DONE.
  - If rvalid arrives in the same cycle as gnt while still in REQ, it is ignored; the bus returns rdata no earlier than the cycle after gnt.
- Timeout: when the counter reaches TIMEOUT_CYCLES in REQ or WAIT:
  - drop bus_req;
  - pulse timeout_err;
  - load_data=0, with no load_valid;
  - go to DONE.
- State DONE: stall=0 for exactly one cycle so the pipeline advances. The current MEM inputs are ignored (they still show the completed instruction). Clear the counter; go to IDLE.
- Latency:
  - store with gnt in the first REQ cycle: stall high for 2 cycles;
  - load with immediate gnt and rvalid the next cycle: stall high for 3 cycles.
- Byte lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111; wdata = data.
  - Reads: be=4'b1111; bus_wdata = 0.
- Load formatting: select the byte/halfword using the addr[1:0] registered at issue. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Non-access cycles in IDLE: stall=0, all pulses 0.

Decomposition:
- Package mem_ctrl_pkg:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW;
  - state encoding IDLE/REQ/WAIT/DONE (2-bit).
- Sub-module mem_lane_align (combinational): computes be, wdata replication, misalign/illegal detection, and load extraction/extension. Instantiated once; the FSM and counter stay in mem_access_ctrl.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt in first REQ cycle -> bus_be=4'hF, bus_addr=0x100, bus_wdata=0xDEADBEEF; stall high 2 cycles, low in DONE.
- LB addr 0x203, rdata 0x80FF_FF7F -> load_data=0xFFFFFF80, load_valid pulse. Repeat as LBU -> 0x00000080.
- SH addr 0x302, data 0x1234ABCD -> be=4'b1100, wdata=0xABCDABCD. Then LH addr 0x301 -> access_err pulse, no bus_req, stall never asserted.
- Load with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> bus_req held until gnt, stall high throughout, exactly one load_valid pulse.
- TIMEOUT_CYCLES=4, gnt never asserted -> bus_req drops after 4 REQ cycles, timeout_err pulse, load_data=0, DONE then IDLE.
- reset_n low during WAIT, then a late bus_rvalid -> all outputs 0 after the reset edge; late rvalid ignored; next access proceeds normally.
